// File: rtl/fp16_pkg.sv
// Shared FP16 types and helpers for the adder scheduler codebase slice.
package fp16_pkg;

  localparam int unsigned FP16_W    = 16;
  localparam int unsigned FP16_SIGN = 15;

  typedef logic [FP16_W-1:0] fp16_t;

  function automatic fp16_t fp16_negate(input fp16_t x);
    fp16_t r;
    r            = x;
    r[FP16_SIGN] = ~x[FP16_SIGN];
    return r;
  endfunction

endpackage

// File: rtl/fp16_sync_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty; push and pop may coincide when full.
module fp16_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign count   = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fp16_add_scheduler.sv
// Round-robin sharing of one FP16 adder among NREQ clients, with in-order tagged result return.
module fp16_add_scheduler
  import fp16_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 add_valid,
  input  logic                 add_ready,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic                 sum_valid,
  input  logic [15:0]          sum,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [15:0]          rsp_sum,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [TW-1:0] rr_q, winner, cand;
  logic          found, accept, rsp_pop, sum_ok;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          add_valid_q;
  fp16_t         add_a_q, add_b_q, sel_a, sel_b;
  logic          tag_full, tag_empty, res_full, res_empty;
  logic [TW-1:0] tag_head;
  fp16_t         res_head;
  logic [CW-1:0] tag_count, res_count;
  logic          err_q;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = TW'((32'(rr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign accept = found && !rst && (!add_valid_q || add_ready) &&
                  (inflight_q < CW'(DEPTH)) && !tag_full;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    sel_a = req_a[FP16_W*winner +: FP16_W];
    sel_b = req_b[FP16_W*winner +: FP16_W];
    if (req_sub[winner]) sel_b = fp16_negate(sel_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rr_q        <= '0;
    end else if (accept) begin
      add_valid_q <= 1'b1;
      add_a_q     <= sel_a;
      add_b_q     <= sel_b;
      rr_q        <= (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    end else if (add_ready) begin
      add_valid_q <= 1'b0;
    end
  end

  assign add_valid = add_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;

  // A sum is only legitimate if some issued tag is still waiting for its result.
  assign sum_ok  = sum_valid && !rst && (tag_count != res_count) && (!res_full || rsp_pop);
  assign rsp_pop = !rst && !res_empty && rsp_ready[tag_head];

  always_comb begin
    rsp_valid = '0;
    if (!res_empty) rsp_valid[tag_head] = 1'b1;
  end

  assign rsp_sum = res_empty ? '0 : res_head;

  always_comb begin
    inflight_d = inflight_q;
    unique case ({accept, rsp_pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (sum_valid && !sum_ok) err_q <= 1'b1;
    end
  end

  assign err  = err_q;
  assign busy = (inflight_q != '0) || add_valid_q;

  fp16_sync_fifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (winner),
    .pop       (rsp_pop),
    .full      (tag_full),
    .empty     (tag_empty),
    .head      (tag_head),
    .count     (tag_count)
  );

  fp16_sync_fifo #(
    .WIDTH (FP16_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sum_ok),
    .push_data (sum),
    .pop       (rsp_pop && !tag_empty),
    .full      (res_full),
    .empty     (res_empty),
    .head      (res_head),
    .count     (res_count)
  );

endmodule

// File: tb/tb_fp16_add_scheduler.sv
// Directed bench for fp16_add_scheduler with NREQ=2, DEPTH=4.
module tb_fp16_add_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b;
  logic        add_valid, add_ready, sum_valid, busy, err;
  logic [15:0] add_a, add_b, sum, rsp_sum;

  int n_checks = 0;
  int n_fail   = 0;
  int accepts;

  always #5 clk = ~clk;

  fp16_add_scheduler #(
    .NREQ  (2),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .add_valid (add_valid),
    .add_ready (add_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .sum_valid (sum_valid),
    .sum       (sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .busy      (busy),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
    add_ready = 1'b0; sum_valid = 1'b0; sum = '0; rsp_ready = '0;
    tick(); tick();

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_add_valid", 32'(add_valid), 32'h0);
    chk("rst_add_a",     32'(add_a),     32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_err",       32'(err),       32'h0);
    rst = 1'b0;

    // Single op from requester 0
    req_valid = 2'b01; req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4000;
    #1 chk("single_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("single_add_valid", 32'(add_valid), 32'h1);
    chk("single_add_a",     32'(add_a),     32'h3C00);
    chk("single_add_b",     32'(add_b),     32'h4000);
    chk("single_busy",      32'(busy),      32'h1);
    add_ready = 1'b1;
    tick();
    add_ready = 1'b0;
    chk("single_issued", 32'(add_valid), 32'h0);
    tick(); tick();
    sum_valid = 1'b1; sum = 16'h4200;
    #1 chk("single_no_bypass", 32'(rsp_valid), 32'h0);
    tick();
    sum_valid = 1'b0;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_sum",   32'(rsp_sum),   32'h4200);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    chk("single_rsp_done", 32'(rsp_valid), 32'h0);
    chk("single_idle",     32'(busy),      32'h0);

    // Subtract from requester 1
    req_valid = 2'b10; req_a[31:16] = 16'h4400; req_b[31:16] = 16'h3C00; req_sub = 2'b10;
    tick();
    req_valid = '0; req_sub = '0;
    chk("sub_add_a", 32'(add_a), 32'h4400);
    chk("sub_add_b", 32'(add_b), 32'hBC00);
    add_ready = 1'b1;
    tick();
    add_ready = 1'b0; sum_valid = 1'b1; sum = 16'h4000;
    tick();
    sum_valid = 1'b0;
    chk("sub_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("sub_rsp_sum",   32'(rsp_sum),   32'h4000);
    rsp_ready = 2'b01;
    tick();
    chk("sub_wrong_ready_ignored", 32'(rsp_valid), 32'h2);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;
    chk("sub_rsp_done", 32'(rsp_valid), 32'h0);

    // Fairness after reset, then credit limit
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11; add_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("fair_grant%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    #1 chk("credit_full_block", 32'(req_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      sum_valid = 1'b1; sum = 16'h1000 + 16'(i);
      tick();
    end
    sum_valid = 1'b0;
    #1 chk("credit_still_block", 32'(req_ready), 32'h0);
    chk("credit_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("credit_rsp_sum",   32'(rsp_sum),   32'h1000);
    rsp_ready = 2'b01;
    #1 chk("credit_no_same_cycle", 32'(req_ready), 32'h0);
    tick();
    rsp_ready = '0;
    #1 chk("credit_one_more", 32'(req_ready), 32'h1);
    tick();
    #1 chk("credit_block_again", 32'(req_ready), 32'h0);
    chk("credit_next_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("credit_next_rsp_sum",   32'(rsp_sum),   32'h1001);

    // Backpressure: operands held while adder stalls
    rst = 1'b1; req_valid = '0; add_ready = 1'b0;
    tick();
    rst = 1'b0;
    req_valid = 2'b01; req_a[15:0] = 16'h1234; req_b[15:0] = 16'h5678;
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      #1 accepts += int'(req_ready[0]);
      tick();
      chk($sformatf("bp_add_a%0d", i), 32'(add_a), 32'h1234);
      chk($sformatf("bp_add_b%0d", i), 32'(add_b), 32'h5678);
      req_a[15:0] = 16'h1111 * 16'(i + 1); req_b[15:0] = 16'h2222 + 16'(i);
    end
    chk("bp_accepts", 32'(accepts), 32'd1);
    req_valid = '0; add_ready = 1'b1;
    tick();
    add_ready = 1'b0; sum_valid = 1'b1; sum = 16'hAAAA;
    tick();
    sum_valid = 1'b0;
    chk("bp_rsp_sum", 32'(rsp_sum), 32'hAAAA);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    chk("bp_drained", 32'(busy), 32'h0);
    chk("bp_no_err",  32'(err),  32'h0);
    sum_valid = 1'b1; sum = 16'h5555;
    tick();
    sum_valid = 1'b0;
    chk("err_set",       32'(err),       32'h1);
    chk("err_sum_drop",  32'(rsp_valid), 32'h0);
    tick(); tick(); tick();
    chk("err_sticky",    32'(err),       32'h1);

    // Reset mid-flight
    req_valid = 2'b11; add_ready = 1'b1;
    tick(); tick(); tick();
    req_valid = '0; add_ready = 1'b0;
    chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_req_ready", 32'(req_ready), 32'h0);
    chk("mid_add_valid", 32'(add_valid), 32'h0);
    chk("mid_add_a",     32'(add_a),     32'h0);
    chk("mid_add_b",     32'(add_b),     32'h0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rsp_sum",   32'(rsp_sum),   32'h0);
    chk("mid_busy_clr",  32'(busy),      32'h0);
    chk("mid_err_clr",   32'(err),       32'h0);
    rst = 1'b0; sum_valid = 1'b1; sum = 16'h3C00;
    tick();
    sum_valid = 1'b0;
    chk("post_rst_sum_err", 32'(err), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_add_scheduler.md
# fp16_add_scheduler

Shares one half-precision (FP16) adder datapath among `NREQ` requesters. Each request carries two FP16 operands and an add/subtract flag. The block round-robin arbitrates, issues operations to the adder through a registered valid/ready port, and tracks in-flight tags. It then returns each result to the requester that issued it, in issue order. It sits between the client units and the adder top level (alignment → add → normalize → round) and keeps a credit count so adder results can never be dropped.

## Interface
Parameters:
- `NREQ`, 2 — requester count, 2..8.
- `DEPTH`, 4 — maximum number of operations in flight (issued or buffered, not yet returned); power of two, 2..16.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  NREQ — request i pending.
- `req_ready`  out  NREQ — request i accepted this cycle.
- `req_a`  in  NREQ*16 — operand A of requester i, bits [16i+15:16i].
- `req_b`  in  NREQ*16 — operand B of requester i.
- `req_sub`  in  NREQ — 1 = compute A−B; the block flips B[15] before issue.
- `add_valid`  out  1 — issue register holds an operation.
- `add_ready`  in  1 — adder accepts the operation.
- `add_a`, `add_b`  out  16 — issued operands.
- `sum_valid`  in  1 — adder result strobe; in order, no backpressure.
- `sum`  in  16 — adder result.
- `rsp_valid`  out  NREQ — one-hot; result at FIFO head belongs to requester i.
- `rsp_ready`  in  NREQ — requester i consumes the result.
- `rsp_sum`  out  16 — head result, shared by all requesters.
- `busy`  out  1 — in-flight count ≠ 0 or issue register full.
- `err`  out  1 — sticky: a `sum_valid` arrived with no pending tag, or the result FIFO overflowed.

## Operation
- **Arbitration:** round-robin, combinational. Search starts at pointer `rr`. The winner is the first i with `req_valid[i]`, scanning from `rr` upward and wrapping.
- **Accept condition:** `req_ready[winner]` = (issue register empty OR `add_ready`) AND `inflight < DEPTH`. All other `req_ready` bits are 0.
- **On accept:**
  - Load the issue register with {A, B ^ (req_sub<<15)}.
  - Push the winner index into the tag FIFO.
  - Set `rr` to winner+1 mod NREQ.
  - Increment `inflight`.
- **Issue handshake:** when `add_valid && add_ready`, the register empties unless it is refilled in the same cycle. Back-to-back issue runs at one operation per cycle.
- **Result path:** `sum_valid` pushes `sum` into the result FIFO (depth DEPTH).
- **Response:** when the result FIFO is non-empty, `rsp_valid[tag_head]` = 1 and `rsp_sum` = result head. On `rsp_ready[tag_head]`, pop both FIFOs and decrement `inflight`.
  - `rsp_ready` bits of other requesters are ignored.
- **Simultaneous accept and pop:** `inflight` is unchanged. Simultaneous push and pop on either FIFO is legal at any fill level, including full.
- **Errors:** `sum_valid` with the result FIFO full, or when (tags pending − results buffered) = 0 → set `err` and drop the sum. `err` clears only on `rst`.
- **No operand inspection:** NaN, Inf, zero and subnormal operands pass through unchanged. Special-case handling belongs to the adder.

## Timing
- **Reset:**
  - All outputs are 0: `req_ready`, `add_valid`, `add_a`, `add_b`, `rsp_valid`, `rsp_sum`, `busy`, `err`.
  - Internal state cleared: `rr` = 0, `inflight` = 0, both FIFOs empty.
  - Reset mid-operation discards all in-flight work. Sums arriving after reset are flagged by `err`.
- **Latency:**
  - Accept at cycle t → `add_valid` at t+1.
  - `sum_valid` at cycle s → `rsp_valid` at s+1. The result FIFO is registered; there is no bypass.
- **Widths:** `inflight` is $clog2(DEPTH)+1 bits. FIFO pointers are $clog2(DEPTH)+1 bits, with the MSB used for full/empty.
- **Stability:** once asserted, `add_valid`, `add_a` and `add_b` stay stable until `add_ready`. `rsp_valid` and `rsp_sum` stay stable until consumed.

## Structure
- **Package `fp16_pkg`:**
  - `FP16_W` = 16, `FP16_SIGN` = 15.
  - typedef `fp16_t` (logic [15:0]).
  - Function `fp16_negate`.
- **Sub-module `fp16_sync_fifo`** (params WIDTH, DEPTH; push/pop/full/empty/head). Instantiated twice: tag FIFO (WIDTH = $clog2(NREQ), minimum 1) and result FIFO (WIDTH = 16).
- Arbiter, issue register and credit counter are written inline.

## Test plan
- **Single op:** NREQ=2, DEPTH=4. Req0 a=0x3C00 b=0x4000 sub=0; model adder returns 0x4200 after 3 cycles → `add_valid` one cycle after accept; `rsp_valid`=2'b01 with `rsp_sum`=0x4200 one cycle after `sum_valid`.
- **Subtract:** req1 a=0x4400 b=0x3C00 sub=1 → `add_b`=0xBC00; response routed to requester 1.
- **Fairness:** both requesters valid continuously, `add_ready`=1, prompt responses → grants alternate 0,1,0,1. After reset the first grant is requester 0.
- **Credit limit:** `add_ready`=1, adder result held back, all `rsp_ready`=0 → exactly 4 accepts, then `req_ready`=0. One response pop → exactly one further accept.
- **Backpressure:** `add_ready`=0 for 5 cycles → `add_a`/`add_b` stable and at most one accept. Then pulse `sum_valid` with nothing pending → `err`=1 and stays 1 until `rst`.
- **Reset mid-flight:** assert `rst` with 3 operations in flight → next cycle all outputs are 0 and `busy`=0.
